// File: rtl/timer_counter.sv
// Programmable down-counting timer with a 3-word register window and a maskable,
// level-sensitive interrupt. Supports one-shot and auto-reload modes.
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_t;

    localparam logic [1:0] IDX_CTRL   = 2'd0;
    localparam logic [1:0] IDX_PRESET = 2'd1;
    localparam logic [1:0] IDX_COUNT  = 2'd2;

    state_t      state, state_nxt;
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count, count_nxt;
    logic        irq_flag, flag_nxt;
    logic        en_clr;

    logic [1:0] idx;
    logic       en, im;
    logic [1:0] mode;
    logic       unused_addr;

    assign idx         = Addr[3:2];
    assign en          = ctrl[0];
    assign mode        = ctrl[2:1];
    assign im          = ctrl[3];
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};

    // A bus write freezes the whole sequencer for that cycle.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        flag_nxt  = irq_flag;
        en_clr    = 1'b0;
        if (!WE) begin
            case (state)
                IDLE: if (en) begin
                    state_nxt = LOAD;
                    flag_nxt  = 1'b0;
                end
                LOAD: begin
                    count_nxt = preset;
                    state_nxt = CNT;
                end
                CNT: begin
                    if (!en) begin
                        state_nxt = IDLE;
                    end else if (count > 32'd1) begin
                        count_nxt = count - 32'd1;
                    end else begin
                        count_nxt = 32'd0;
                        flag_nxt  = 1'b1;
                        state_nxt = INT;
                    end
                end
                INT: begin
                    state_nxt = IDLE;
                    // Auto-reload drops the flag; every other mode is one-shot and keeps it.
                    if (mode == 2'b01) flag_nxt = 1'b0;
                    else               en_clr   = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            ctrl     <= 4'd0;
            preset   <= 32'd0;
            count    <= 32'd0;
            irq_flag <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            irq_flag <= flag_nxt;
            if (WE && idx == IDX_CTRL) ctrl    <= Din[3:0];
            else if (en_clr)           ctrl[0] <= 1'b0;
            if (WE && idx == IDX_PRESET) preset <= Din;
        end
    end

    always_comb begin
        case (idx)
            IDX_CTRL:   Dout = {28'd0, ctrl};
            IDX_PRESET: Dout = preset;
            IDX_COUNT:  Dout = count;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = im & irq_flag;
endmodule

// File: tb/tb_timer_counter.sv
// Bench for timer_counter: register-access vector table plus hand-written
// sequences for one-shot, auto-reload, masking, write priority and reset.
module tb_timer_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Addr = 32'd0;
    logic        WE = 1'b0;
    logic [31:0] Din = 32'd0;
    logic [31:0] Dout;
    logic        IRQ;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic [31:0] exp;
    } sb_item_t;
    sb_item_t sb[$];

    typedef struct {
        logic        we;
        logic [1:0]  widx;
        logic [31:0] din;
        logic [1:0]  ridx;
        logic [31:0] exp_dout;
        logic        exp_irq;
    } vec_t;
    vec_t vecs[6];

    timer_counter dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    always #5 clk = ~clk;

    task automatic compare(input logic [31:0] act);
        sb_item_t it;
        it = sb.pop_front();
        checks++;
        if (act !== it.exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", it.name, act, it.exp);
        end
    endtask

    task automatic chk_dout(input string nm, input logic [1:0] idx, input logic [31:0] exp);
        Addr = {28'd0, idx, 2'b00};
        sb.push_back('{nm, exp});
        #1;
        compare(Dout);
    endtask

    task automatic chk_irq(input string nm, input logic exp);
        sb.push_back('{nm, {31'd0, exp}});
        compare({31'd0, IRQ});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [1:0] idx, input logic [31:0] d);
        WE = 1'b1;
        Addr = {28'd0, idx, 2'b00};
        Din = d;
        @(negedge clk);
        WE = 1'b0;
        Din = 32'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b1, 2'd1, 32'hDEADBEEF, 2'd1, 32'hDEADBEEF, 1'b0};
        vecs[1] = '{1'b1, 2'd0, 32'hFFFFFFF6, 2'd0, 32'h00000006, 1'b0};
        vecs[2] = '{1'b1, 2'd2, 32'h00001234, 2'd2, 32'h00000000, 1'b0};
        vecs[3] = '{1'b1, 2'd3, 32'h0000FFFF, 2'd3, 32'h00000000, 1'b0};
        vecs[4] = '{1'b0, 2'd0, 32'h00000000, 2'd1, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{1'b0, 2'd0, 32'h00000000, 2'd0, 32'h00000006, 1'b0};

        @(negedge clk);
        // reset overrides a simultaneous write
        reset = 1'b1; WE = 1'b1; Addr = 32'h4; Din = 32'h55;
        @(negedge clk);
        reset = 1'b0; WE = 1'b0; Din = 32'd0;
        for (int i = 0; i < 4; i++) chk_dout($sformatf("reset_dout%0d", i), i[1:0], 32'd0);
        chk_irq("reset_irq", 1'b0);

        // register access table; index 2/3 writes must not disturb anything
        for (int i = 0; i < 6; i++) begin
            WE = vecs[i].we;
            Addr = {28'd0, vecs[i].widx, 2'b00};
            Din = vecs[i].din;
            @(negedge clk);
            WE = 1'b0;
            Din = 32'd0;
            chk_dout($sformatf("vec%0d_dout", i), vecs[i].ridx, vecs[i].exp_dout);
            chk_irq($sformatf("vec%0d_irq", i), vecs[i].exp_irq);
        end

        // one-shot, PRESET=5
        do_reset();
        wr(2'd1, 32'd5);
        wr(2'd0, 32'h9);
        chk_dout("os_ctrl", 2'd0, 32'h9);
        step(1);
        chk_irq("os_irq_e1", 1'b0);
        for (int k = 2; k <= 6; k++) begin
            step(1);
            chk_dout($sformatf("os_count_e%0d", k), 2'd2, 32'(7 - k));
            chk_irq($sformatf("os_irq_e%0d", k), 1'b0);
        end
        step(1);
        chk_dout("os_count_e7", 2'd2, 32'd0);
        chk_irq("os_irq_e7", 1'b1);
        step(1);
        chk_dout("os_ctrl_after_int", 2'd0, 32'h8);
        chk_irq("os_irq_e8", 1'b1);
        step(3);
        chk_irq("os_irq_hold", 1'b1);
        wr(2'd0, 32'h9);
        chk_irq("os_irq_after_rewrite", 1'b1);
        step(1);
        chk_irq("os_irq_cleared_on_load", 1'b0);

        // auto-reload, PRESET=3: IRQ pulses on edges 5, 11, 17, 23
        do_reset();
        wr(2'd1, 32'd3);
        wr(2'd0, 32'hB);
        for (int k = 1; k <= 24; k++) begin
            step(1);
            chk_irq($sformatf("ar_irq_e%0d", k), (k >= 5) && ((k - 5) % 6 == 0));
        end
        chk_dout("ar_ctrl", 2'd0, 32'hB);

        // masked interrupt, then unmask while flag is set
        do_reset();
        wr(2'd1, 32'd2);
        wr(2'd0, 32'h1);
        for (int k = 1; k <= 6; k++) begin
            step(1);
            chk_irq($sformatf("mask_irq_e%0d", k), 1'b0);
        end
        chk_dout("mask_ctrl_en_cleared", 2'd0, 32'h0);
        wr(2'd0, 32'h8);
        chk_irq("mask_unmasked_irq", 1'b1);

        // write priority: PRESET writes during CNT freeze COUNT
        do_reset();
        wr(2'd1, 32'd20);
        wr(2'd0, 32'h1);
        step(12);
        chk_dout("wp_count_pre", 2'd2, 32'd10);
        WE = 1'b1; Addr = 32'h4; Din = 32'd77;
        step(3);
        WE = 1'b0; Din = 32'd0;
        chk_dout("wp_count_held", 2'd2, 32'd10);
        chk_dout("wp_preset_new", 2'd1, 32'd77);
        step(1);
        chk_dout("wp_count_resume", 2'd2, 32'd9);

        // PRESET 0 and 1 both hit INT after one CNT cycle
        for (int p = 0; p < 2; p++) begin
            do_reset();
            wr(2'd1, 32'(p));
            wr(2'd0, 32'h9);
            step(2);
            chk_irq($sformatf("p%0d_irq_e2", p), 1'b0);
            step(1);
            chk_irq($sformatf("p%0d_irq_e3", p), 1'b1);
            chk_dout($sformatf("p%0d_count", p), 2'd2, 32'd0);
        end

        // EN cleared while in LOAD: COUNT still loaded, then back to IDLE
        do_reset();
        wr(2'd1, 32'd4);
        wr(2'd0, 32'h1);
        step(1);
        wr(2'd0, 32'h0);
        chk_dout("ld_count_before", 2'd2, 32'd0);
        step(1);
        chk_dout("ld_count_loaded", 2'd2, 32'd4);
        step(3);
        chk_dout("ld_count_held", 2'd2, 32'd4);
        chk_irq("ld_irq", 1'b0);

        // reset mid-count
        do_reset();
        wr(2'd1, 32'd10);
        wr(2'd0, 32'h9);
        step(5);
        chk_dout("rm_count_pre", 2'd2, 32'd7);
        do_reset();
        for (int i = 0; i < 4; i++) chk_dout($sformatf("rm_dout%0d", i), i[1:0], 32'd0);
        chk_irq("rm_irq", 1'b0);
        step(12);
        chk_irq("rm_irq_later", 1'b0);
        chk_dout("rm_count_later", 2'd2, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
